// File: rtl/mac_pkg.sv
// Shared definitions for the MAC result drain: width helpers and FSM state encoding.
package mac_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  function automatic int calc_m_width(input int n, input int width);
    return 2 * width + n - 1;
  endfunction

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mac_frame_fifo.sv
// Two-entry frame buffer: writes a whole N-lane frame, reads one lane of the head frame by index.
module mac_frame_fifo
  import mac_pkg::*;
#(
  parameter int N       = 5,
  parameter int M_WIDTH = 36
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_flush,
  input  logic                       i_wr_en,
  input  logic [N*M_WIDTH-1:0]       i_wr_frame,
  input  logic                       i_rd_free,
  input  logic [idx_width(N)-1:0]    i_rd_idx,
  output logic [M_WIDTH-1:0]         o_rd_word,
  output logic [1:0]                 o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  logic [N*M_WIDTH-1:0] r_mem [2];
  logic                 r_wr_ptr;
  logic                 r_rd_ptr;
  logic [1:0]           r_count;
  logic [N*M_WIDTH-1:0] w_head;
  logic [M_WIDTH-1:0]   w_lanes [N];

  assign w_head = r_mem[r_rd_ptr];

  for (genvar g = 0; g < N; g++) begin : g_lane
    assign w_lanes[g] = w_head[g*M_WIDTH +: M_WIDTH];
  end

  assign o_rd_word = w_lanes[i_rd_idx];
  assign o_count   = r_count;
  assign o_full    = (r_count == 2'd2);
  assign o_empty   = (r_count == 2'd0);

  // Data storage needs no reset: nothing is read out unless count is nonzero.
  always_ff @(posedge clk) begin
    if (i_wr_en && !i_flush) begin
      r_mem[r_wr_ptr] <= i_wr_frame;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_wr_en) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (i_rd_free) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, i_wr_en} - {1'b0, i_rd_free};
    end
  end

endmodule

// File: rtl/mac_result_drain.sv
// Captures a full MAC-array result frame on the rising edge of all-lanes-valid and
// serializes it lane by lane over a valid/ready port; sticky overflow and lane-error flags.
module mac_result_drain
  import mac_pkg::*;
#(
  parameter int N       = 5,
  parameter int WIDTH   = 16,
  parameter int M_WIDTH = calc_m_width(N, WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N*M_WIDTH-1:0]    C,
  input  logic [N-1:0]            valid,
  input  logic                    clear,
  output logic [M_WIDTH-1:0]      dout,
  output logic [idx_width(N)-1:0] dout_idx,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic                    dout_last,
  output logic                    overflow,
  output logic                    lane_err
);

  localparam int              IW       = idx_width(N);
  localparam logic [IW-1:0]   LAST_IDX = IW'(N - 1);

  state_e             r_state;
  state_e             w_state_nxt;
  logic               r_valid_prev;
  logic [IW-1:0]      r_idx;
  logic               r_overflow;
  logic               r_lane_err;

  logic               w_all;
  logic               w_partial;
  logic               w_capture;
  logic               w_dv;
  logic               w_xfer;
  logic               w_last_xfer;
  logic               w_accept;
  logic               w_drop;
  logic               w_full;
  logic               w_empty;
  logic [1:0]         w_count;
  logic [M_WIDTH-1:0] w_word;

  assign w_all       = &valid;
  assign w_partial   = (|valid) & ~w_all;
  assign w_capture   = w_all & ~r_valid_prev;
  assign w_dv        = (r_state == ST_DRAIN) & ~w_empty;
  assign w_xfer      = w_dv & dout_ready;
  assign w_last_xfer = w_xfer & (r_idx == LAST_IDX);
  // A full buffer still accepts when the head frame is freed on the same edge.
  assign w_accept    = w_capture & ~clear & (~w_full | w_last_xfer);
  assign w_drop      = w_capture & ~clear & w_full & ~w_last_xfer;

  mac_frame_fifo #(
    .N       (N),
    .M_WIDTH (M_WIDTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_flush    (clear),
    .i_wr_en    (w_accept),
    .i_wr_frame (C),
    .i_rd_free  (w_last_xfer & ~clear),
    .i_rd_idx   (r_idx),
    .o_rd_word  (w_word),
    .o_count    (w_count),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_last_xfer && !w_accept && (w_count == 2'd1)) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
    if (clear) begin
      w_state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid_prev <= 1'b0;
      r_idx        <= '0;
      r_overflow   <= 1'b0;
      r_lane_err   <= 1'b0;
    end else begin
      r_valid_prev <= w_all;
      if (clear || w_last_xfer) begin
        r_idx <= '0;
      end else if (w_xfer) begin
        r_idx <= r_idx + 1'b1;
      end
      if (clear) begin
        r_overflow <= 1'b0;
        r_lane_err <= 1'b0;
      end else begin
        if (w_drop)    r_overflow <= 1'b1;
        if (w_partial) r_lane_err <= 1'b1;
      end
    end
  end

  assign dout_valid = w_dv;
  assign dout       = w_dv ? w_word : '0;
  assign dout_idx   = r_idx;
  assign dout_last  = w_dv & (r_idx == LAST_IDX);
  assign overflow   = r_overflow;
  assign lane_err   = r_lane_err;

endmodule

// File: tb/tb_mac_result_drain.sv
// Directed, table-driven bench for mac_result_drain (N=5, WIDTH=16, M_WIDTH=36).
module tb_mac_result_drain;

  localparam int N  = 5;
  localparam int MW = 36;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N*MW-1:0] C;
  logic [N-1:0]    valid;
  logic            clear;
  logic [MW-1:0]   dout;
  logic [2:0]      dout_idx;
  logic            dout_valid;
  logic            dout_ready;
  logic            dout_last;
  logic            overflow;
  logic            lane_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mac_result_drain #(.N(N), .WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .C          (C),
    .valid      (valid),
    .clear      (clear),
    .dout       (dout),
    .dout_idx   (dout_idx),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_last  (dout_last),
    .overflow   (overflow),
    .lane_err   (lane_err)
  );

  typedef struct {
    logic [4:0]  v;
    logic        r;
    logic        clr;
    logic [15:0] cb;
    logic        e_dv;
    logic [15:0] e_cb;
    logic [2:0]  e_idx;
    logic        e_ovf;
    logic        e_err;
  } vec_t;

  vec_t tbl[$];

  // Lane i of frame "cb" carries {cb, i+1}; cb=0 gives lanes 1..5.
  function automatic logic [MW-1:0] lane_word(input logic [15:0] cb, input int i);
    return {cb, 20'(i + 1)};
  endfunction

  function automatic vec_t mk(input logic [4:0] v, input logic r, input logic clr,
                              input logic [15:0] cb, input logic e_dv, input logic [15:0] e_cb,
                              input int e_idx, input logic e_ovf, input logic e_err);
    vec_t t;
    t.v = v; t.r = r; t.clr = clr; t.cb = cb;
    t.e_dv = e_dv; t.e_cb = e_cb; t.e_idx = 3'(e_idx); t.e_ovf = e_ovf; t.e_err = e_err;
    return t;
  endfunction

  task automatic set_frame(input logic [15:0] cb);
    for (int i = 0; i < N; i++) C[i*MW +: MW] = lane_word(cb, i);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic e_dv, input logic [15:0] e_cb, input int e_idx);
    chk({tag, " dout_valid"}, 64'(dout_valid), 64'(e_dv));
    chk({tag, " dout"}, 64'(dout), e_dv ? 64'(lane_word(e_cb, e_idx)) : 64'd0);
    chk({tag, " dout_idx"}, 64'(dout_idx), e_dv ? 64'(e_idx) : 64'd0);
    chk({tag, " dout_last"}, 64'(dout_last), 64'(e_dv && (e_idx == 4)));
  endtask

  initial begin
    // Single frame, 1-cycle latency, lanes 1..5
    tbl.push_back(mk(5'h00, 1, 0, 16'h0, 0, 16'h0, 0, 0, 0));
    tbl.push_back(mk(5'h1F, 1, 0, 16'h0, 1, 16'h0, 0, 0, 0));
    for (int k = 1; k < 5; k++) tbl.push_back(mk(5'h00, 1, 0, 16'h0, 1, 16'h0, k, 0, 0));
    tbl.push_back(mk(5'h00, 1, 0, 16'h0, 0, 16'h0, 0, 0, 0));
    // Backpressure held at lane 2 for 3 cycles
    tbl.push_back(mk(5'h1F, 0, 0, 16'h0, 1, 16'h0, 0, 0, 0));
    tbl.push_back(mk(5'h00, 1, 0, 16'h0, 1, 16'h0, 1, 0, 0));
    tbl.push_back(mk(5'h00, 1, 0, 16'h0, 1, 16'h0, 2, 0, 0));
    for (int k = 0; k < 3; k++) tbl.push_back(mk(5'h00, 0, 0, 16'h0, 1, 16'h0, 2, 0, 0));
    tbl.push_back(mk(5'h00, 1, 0, 16'h0, 1, 16'h0, 3, 0, 0));
    tbl.push_back(mk(5'h00, 1, 0, 16'h0, 1, 16'h0, 4, 0, 0));
    tbl.push_back(mk(5'h00, 1, 0, 16'h0, 0, 16'h0, 0, 0, 0));
    // Partial valid then clear
    tbl.push_back(mk(5'h07, 1, 0, 16'h0, 0, 16'h0, 0, 0, 1));
    tbl.push_back(mk(5'h00, 1, 1, 16'h0, 0, 16'h0, 0, 0, 0));
    // Overflow: A, B buffered, C dropped
    tbl.push_back(mk(5'h1F, 0, 0, 16'hA, 1, 16'hA, 0, 0, 0));
    tbl.push_back(mk(5'h00, 0, 0, 16'hA, 1, 16'hA, 0, 0, 0));
    tbl.push_back(mk(5'h1F, 0, 0, 16'hB, 1, 16'hA, 0, 0, 0));
    tbl.push_back(mk(5'h00, 0, 0, 16'hB, 1, 16'hA, 0, 0, 0));
    tbl.push_back(mk(5'h1F, 0, 0, 16'hC, 1, 16'hA, 0, 1, 0));
    for (int k = 1; k < 5; k++) tbl.push_back(mk(5'h00, 1, 0, 16'hC, 1, 16'hA, k, 1, 0));
    for (int k = 0; k < 5; k++) tbl.push_back(mk(5'h00, 1, 0, 16'hC, 1, 16'hB, k, 1, 0));
    tbl.push_back(mk(5'h00, 1, 0, 16'hC, 0, 16'h0, 0, 1, 0));
    tbl.push_back(mk(5'h00, 1, 1, 16'hC, 0, 16'h0, 0, 0, 0));
    // Capture D on the cycle A lane 4 transfers while full
    tbl.push_back(mk(5'h1F, 0, 0, 16'hA, 1, 16'hA, 0, 0, 0));
    tbl.push_back(mk(5'h00, 0, 0, 16'hA, 1, 16'hA, 0, 0, 0));
    tbl.push_back(mk(5'h1F, 0, 0, 16'hB, 1, 16'hA, 0, 0, 0));
    for (int k = 1; k < 5; k++) tbl.push_back(mk(5'h00, 1, 0, 16'hB, 1, 16'hA, k, 0, 0));
    tbl.push_back(mk(5'h1F, 1, 0, 16'hD, 1, 16'hB, 0, 0, 0));
    for (int k = 1; k < 5; k++) tbl.push_back(mk(5'h00, 1, 0, 16'hD, 1, 16'hB, k, 0, 0));
    for (int k = 0; k < 5; k++) tbl.push_back(mk(5'h00, 1, 0, 16'hD, 1, 16'hD, k, 0, 0));
    tbl.push_back(mk(5'h00, 1, 0, 16'hD, 0, 16'h0, 0, 0, 0));
    // Clear wins over a capture edge
    tbl.push_back(mk(5'h1F, 1, 1, 16'hA, 0, 16'h0, 0, 0, 0));
    tbl.push_back(mk(5'h00, 1, 0, 16'hA, 0, 16'h0, 0, 0, 0));
    // Full-width data with the MSB set
    tbl.push_back(mk(5'h1F, 1, 0, 16'hFFFF, 1, 16'hFFFF, 0, 0, 0));
    for (int k = 1; k < 5; k++) tbl.push_back(mk(5'h00, 1, 0, 16'hFFFF, 1, 16'hFFFF, k, 0, 0));
    tbl.push_back(mk(5'h00, 1, 0, 16'hFFFF, 0, 16'h0, 0, 0, 0));

    rst_n = 1'b0;
    valid = '0;
    clear = 1'b0;
    dout_ready = 1'b1;
    C = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_word("reset", 1'b0, 16'h0, 0);
    chk("reset overflow", 64'(overflow), 64'd0);
    chk("reset lane_err", 64'(lane_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      automatic vec_t t;
      automatic string tag;
      t = tbl[i];
      tag = $sformatf("row%0d", i);
      @(negedge clk);
      valid = t.v;
      dout_ready = t.r;
      clear = t.clr;
      set_frame(t.cb);
      @(posedge clk);
      #1;
      chk_word(tag, t.e_dv, t.e_cb, int'(t.e_idx));
      chk({tag, " overflow"}, 64'(overflow), 64'(t.e_ovf));
      chk({tag, " lane_err"}, 64'(lane_err), 64'(t.e_err));
    end

    // Reset mid-drain at lane 2
    @(negedge clk);
    clear = 1'b0;
    dout_ready = 1'b1;
    set_frame(16'h0123);
    valid = 5'h1F;
    @(posedge clk);
    #1;
    chk_word("rst_seq start", 1'b1, 16'h0123, 0);
    @(negedge clk);
    valid = 5'h00;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_word("rst_seq lane2", 1'b1, 16'h0123, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_word("rst_seq async", 1'b0, 16'h0, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("rst_seq idle%0d dout_valid", k), 64'(dout_valid), 64'd0);
    end
    @(negedge clk);
    valid = 5'h1F;
    @(posedge clk);
    #1;
    chk_word("rst_seq recapture", 1'b1, 16'h0123, 0);
    @(negedge clk);
    valid = 5'h00;
    repeat (6) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mac_result_drain.md
MAC_RESULT_DRAIN -- requirements
Module: mac_result_drain

Interface
REQ-001 The block SHALL have parameter N, default 5, meaning the number of MAC lanes and words per result frame.
REQ-002 The block SHALL have parameter WIDTH, default 16, meaning the MAC operand width.
REQ-003 The block SHALL have parameter M_WIDTH, default 2*WIDTH+N-1, meaning the per-lane accumulator result width.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit, the reset: asynchronous, active-low.
REQ-006 The block SHALL have port C, input, N*M_WIDTH bits, lane i result at bits [M_WIDTH*(i+1)-1 : M_WIDTH*i].
REQ-007 The block SHALL have port valid, input, N bits, per-lane result-valid from the MAC array.
REQ-008 The block SHALL have port clear, input, 1 bit, synchronous flush of the buffer and sticky flags.
REQ-009 The block SHALL have port dout, output, M_WIDTH bits, the serialized result word.
REQ-010 The block SHALL have port dout_idx, output, clog2(N) bits, the lane index of dout.
REQ-011 The block SHALL have port dout_valid, output, 1 bit, asserted when dout holds a word.
REQ-012 The block SHALL have port dout_ready, input, 1 bit, the consumer accept signal.
REQ-013 The block SHALL have port dout_last, output, 1 bit, asserted with the lane N-1 word.
REQ-014 The block SHALL have port overflow, output, 1 bit, sticky flag for a dropped frame.
REQ-015 The block SHALL have port lane_err, output, 1 bit, sticky flag for a partial-valid frame.

Function
REQ-016 A capture event SHALL be defined as &valid high this cycle and low the previous cycle (rising edge of all-lanes-valid).
REQ-017 On a capture event the block SHALL copy all N lanes of C into a 2-entry frame buffer (FIFO order) when space exists.
REQ-018 A word transfer SHALL occur when dout_valid and dout_ready are both high on a rising clk edge.
REQ-019 dout/dout_idx SHALL present head-frame lanes in order 0..N-1, advancing one lane per transfer and holding while dout_ready is low.
REQ-020 dout_valid SHALL be high exactly when the buffer count is nonzero; dout, dout_idx and dout_last SHALL be stable while dout_valid is high and dout_ready is low.
REQ-021 When the lane N-1 transfer completes, the head frame SHALL be freed, dout_idx SHALL return to 0 and the next frame (if any) SHALL be presented the next cycle with no bubble.
REQ-022 A capture into an empty buffer SHALL present lane 0 with dout_valid high on the cycle after the capture edge (1-cycle latency).
REQ-023 The FSM SHALL have state IDLE (count 0) and state DRAIN (count 1..2); IDLE->DRAIN on capture, DRAIN->IDLE on the last transfer with no concurrent capture and count 1.
REQ-024 For a capture when count=2 with no concurrent frame free, the frame SHALL be dropped, buffer content SHALL be unchanged and overflow SHALL be set.
REQ-025 For a capture on the same cycle as a last transfer when count=2, the frame SHALL be accepted (free before write) and count SHALL remain 2.
REQ-026 If valid is neither all-zero nor all-one for a cycle, lane_err SHALL be set; no capture SHALL occur from that cycle.
REQ-027 clear SHALL empty the buffer, zero dout_idx, drop dout_valid next cycle and clear both sticky flags; clear SHALL take priority over a simultaneous capture.
REQ-028 Buffered data SHALL be stored unmodified at full M_WIDTH with no truncation or sign change.

Reset
REQ-029 While rst_n is low, the block SHALL hold: FSM IDLE, count 0, dout_idx 0, dout 0, dout_valid 0, dout_last 0, overflow 0, lane_err 0, and the previous-valid register 0.
REQ-030 Reset asserted mid-drain SHALL discard all frames; after release, the first capture SHALL require a fresh rising edge of &valid.

Structure
REQ-031 A shared package mac_pkg SHALL hold the M_WIDTH derivation function, the index-width (clog2) function and the state encoding constants.
REQ-032 The 2-entry frame storage SHALL be a sub-module mac_frame_fifo (write-frame, read-lane-by-index, count, full/empty).

Verification
REQ-033 Single frame: with N=5 and M_WIDTH=36, set C lanes to 1,2,3,4,5, pulse valid=5'b11111 with dout_ready=1 -> words 1..5 appear on 5 consecutive cycles starting 1 cycle later, idx 0..4, last high on 5.
REQ-034 Backpressure: hold dout_ready=0 for 3 cycles at lane 2 -> dout=3, idx=2 held stable; the drain resumes when dout_ready rises.
REQ-035 Overflow: capture three frames A, B, C with dout_ready=0 -> overflow=1; drained output is A then B; C is never seen.
REQ-036 Simultaneous event: count=2, capture on the cycle of the A lane-4 transfer -> no overflow; output is A, B, then the new frame.
REQ-037 Partial valid: valid=5'b00111 for 1 cycle -> lane_err=1 and no capture; clear -> lane_err=0.
REQ-038 Reset mid-drain: assert rst_n=0 at lane 2 -> all outputs 0 asynchronously; after release dout_valid stays 0 until a new valid edge.
